fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the write port of one sync FIFO among NUM_REQ requesters.
- Each requester presents valid/ready/data/last. The arbiter grants one requester at a time for a burst of up to MAX_BURST beats.
- The granted stream is forwarded to the FIFO write side: o_valid_s drives the FIFO i_valid_s, and i_ready_s is driven by the FIFO o_ready_s.
- New bursts are held off while the FIFO reports almost-full.

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- DATA_WIDTH, 8, data width per requester and FIFO word
- MAX_BURST, 4, maximum beats per grant before forced release (≥1)

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous reset, active low
- i_req_valid  input  NUM_REQ  per-requester write request
- i_req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_req_last  input  NUM_REQ  marks final beat of requester's burst
- o_req_ready  output  NUM_REQ  per-requester accept
- o_valid_s  output  1  write request to FIFO
- o_data_s  output  DATA_WIDTH  write data to FIFO
- i_ready_s  input  1  FIFO not full (FIFO o_ready_s)
- i_almostfull  input  1  FIFO almost-full flag
- o_grant  output  NUM_REQ  one-hot current grant, registered
- o_busy  output  1  high in GRANT state

Behaviour:
- One clock (clk); reset is asynchronous and active-low (reset_n).
- A transfer (beat) occurs on a cycle where valid=1 and ready=1.
- Requester rule: once i_req_valid[k] is raised, it and the data are held until that beat is accepted.

Reset values:
- state=IDLE
- o_grant=0, o_busy=0, o_valid_s=0, o_req_ready=0, o_data_s=0
- last_winner=NUM_REQ-1, so requester 0 has first priority
- beat_cnt=0

FSM, 2 states (IDLE, GRANT):
- IDLE:
  - If i_almostfull=0 and any i_req_valid is high: select the first valid requester searching upward from last_winner+1 (mod NUM_REQ).
  - Register its one-hot value into o_grant, set last_winner to that index, clear beat_cnt, and go to GRANT.
  - Arbitration latency is 1 cycle.
  - If i_almostfull=1, stay in IDLE regardless of requests.
- GRANT, with granted index g:
  - o_valid_s = i_req_valid[g]
  - o_data_s = i_req_data[g]
  - o_req_ready[g] = i_ready_s; all other o_req_ready bits are 0.
  - The i_ready_s→o_req_ready path is combinational by design.
  - On each beat, beat_cnt increments.
  - Release (go to IDLE, o_grant←0) at the end of a cycle where any of these holds:
    - a beat occurs with i_req_last[g]=1
    - a beat occurs with beat_cnt==MAX_BURST-1
    - i_req_valid[g]=0 (requester went idle)
  - i_almostfull does not terminate an active burst. Only i_ready_s=0 stalls it, and beat_cnt holds during the stall.
  - Every release costs one idle bubble cycle before the next grant.
- Outside GRANT: o_valid_s=0 and o_data_s holds its last value.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - last_winner is $clog2(NUM_REQ) bits; wrap is NUM_REQ-1→0, computed with explicit modulo for non-power-of-2 NUM_REQ.
- Starvation bound: a continuously requesting requester is granted within NUM_REQ-1 other grants.
- Reset mid-burst: all state clears immediately. A beat in flight is dropped, with no partial-state recovery.

Decomposition:
- Shared defines (sync_fifo_defines.vh):
  - FIFO_WR_ARB_IDLE / FIFO_WR_ARB_GRANT state encodings
  - default NUM_REQ
  - default MAX_BURST
- Sub-module rr_arbiter:
  - combinational round-robin picker
  - inputs: req[NUM_REQ], last_winner
  - outputs: one-hot gnt, index, any
  - reusable for a future read-side distributor

Test Plan:
- Reset, then req 0..3 all valid with last on every beat, i_ready_s=1 → grants in order 0,1,2,3,0. Each grant moves one beat, and a 1-cycle bubble follows each release.
- Req 2 alone, 10 beats, last only on beat 10, MAX_BURST=4 → grant released after 4 beats and re-granted to 2 after the bubble. FIFO receives all 10 words in order as bursts of 4,4,2.
- Burst in progress with i_ready_s=0 for 3 cycles → o_req_ready[g]=0 and o_valid_s=1 hold with stable o_data_s, and beat_cnt is frozen. Burst resumes with no loss or duplicate.
- i_almostfull=1 while req 1 and req 3 are valid in IDLE → no grant for the whole interval. After almostfull drops, o_grant=0010 on the next cycle. Also, almostfull asserted mid-burst → burst completes to last.
- Granted requester drops valid after 2 of 4 intended beats → release next edge, and the next requester (round-robin) is granted.
- reset_n pulsed low mid-burst → o_grant=0, o_valid_s=0 and o_busy=0 asynchronously. After reset, the first grant goes to requester 0 when all requesters are valid.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared defaults and state encoding for the FIFO write arbiter
package fifo_wr_arbiter_pkg;

    localparam int DEFAULT_NUM_REQ   = 4;
    localparam int DEFAULT_MAX_BURST = 4;

    typedef enum logic {
        FIFO_WR_ARB_IDLE  = 1'b0,
        FIFO_WR_ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// rtl/fifo_wr_arbiter_rr.sv - combinational round-robin picker, reusable on the read side
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_winner_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        // Start one past the last winner so it ends up with the lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_winner_i) + i) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one sync FIFO write port
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_last,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_valid_s,
    output logic [DATA_WIDTH-1:0]         o_data_s,
    input  logic                          i_ready_s,
    input  logic                          i_almostfull,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e                state_q, state_d;
    logic [NUM_REQ-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]          winner_q, winner_d;
    logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DATA_WIDTH-1:0]     req_data [NUM_REQ];
    logic [NUM_REQ-1:0]        arb_gnt;
    logic [IDX_W-1:0]          arb_idx;
    logic                      arb_any;
    logic                      beat;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_data[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i         (i_req_valid),
        .last_winner_i (winner_q),
        .gnt_o         (arb_gnt),
        .idx_o         (arb_idx),
        .any_o         (arb_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FIFO_WR_ARB_IDLE;
            grant_q    <= '0;
            winner_q   <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            winner_q   <= winner_d;
            beat_cnt_q <= beat_cnt_d;
            data_q     <= data_d;
        end
    end

    // While granted, winner_q is the granted index.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        winner_d    = winner_q;
        beat_cnt_d  = beat_cnt_q;
        data_d      = data_q;
        o_valid_s   = 1'b0;
        o_data_s    = data_q;
        o_req_ready = '0;
        beat        = 1'b0;
        case (state_q)
            FIFO_WR_ARB_IDLE: begin
                if (!i_almostfull && arb_any) begin
                    grant_d    = arb_gnt;
                    winner_d   = arb_idx;
                    beat_cnt_d = '0;
                    state_d    = FIFO_WR_ARB_GRANT;
                end
            end
            FIFO_WR_ARB_GRANT: begin
                o_valid_s             = i_req_valid[winner_q];
                o_data_s              = req_data[winner_q];
                o_req_ready[winner_q] = i_ready_s;
                data_d                = req_data[winner_q];
                beat                  = i_req_valid[winner_q] & i_ready_s;
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if (!i_req_valid[winner_q] ||
                    (beat && (i_req_last[winner_q] || beat_cnt_q == CNT_W'(MAX_BURST - 1)))) begin
                    state_d = FIFO_WR_ARB_IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = FIFO_WR_ARB_IDLE;
        endcase
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q == FIFO_WR_ARB_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and randomized bench with a cycle-level behavioural model
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk          = 1'b0;
    logic            reset_n      = 1'b0;
    logic [N-1:0]    i_req_valid  = '0;
    logic [N*DW-1:0] i_req_data   = '0;
    logic [N-1:0]    i_req_last   = '0;
    logic [N-1:0]    o_req_ready;
    logic            o_valid_s;
    logic [DW-1:0]   o_data_s;
    logic            i_ready_s    = 1'b1;
    logic            i_almostfull = 1'b0;
    logic [N-1:0]    o_grant;
    logic            o_busy;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_req_valid  (i_req_valid),
        .i_req_data   (i_req_data),
        .i_req_last   (i_req_last),
        .o_req_ready  (o_req_ready),
        .o_valid_s    (o_valid_s),
        .o_data_s     (o_data_s),
        .i_ready_s    (i_ready_s),
        .i_almostfull (i_almostfull),
        .o_grant      (o_grant),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            gap;
    } beat_t;

    beat_t        rq [N][$];
    logic [N-1:0] presenting = '0;
    logic [N-1:0] acc        = '0;

    logic          m_busy = 1'b0;
    int            m_g    = 0;
    int            m_lw   = N - 1;
    int            m_beats = 0;
    logic [DW-1:0] m_hold = '0;

    int   glog [$];
    int   blog [$];
    int   flog [$];
    int   exp_q [$];
    int   cur_blen  = 0;
    logic prev_busy = 1'b0;
    logic [N-1:0] prev_valid = '0;
    int   waits [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string name, input int got[$], input int exp[$]);
        chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(name, 32'(got[i]), 32'(exp[i]));
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_g     = 0;
        m_lw    = N - 1;
        m_beats = 0;
        m_hold  = '0;
        acc     = '0;
    endtask

    task automatic model_step();
        logic beat;
        if (!m_busy) begin
            if (!i_almostfull && (i_req_valid != '0)) begin
                int pick;
                pick = -1;
                for (int i = 1; i <= N; i++)
                    if (pick < 0 && i_req_valid[(m_lw + i) % N]) pick = (m_lw + i) % N;
                m_busy  = 1'b1;
                m_g     = pick;
                m_lw    = pick;
                m_beats = 0;
            end
        end else begin
            beat   = i_req_valid[m_g] && i_ready_s;
            m_hold = i_req_data[m_g*DW +: DW];
            if (beat) begin
                acc[m_g] = 1'b1;
                m_beats++;
            end
            if (!i_req_valid[m_g] || (beat && (i_req_last[m_g] || m_beats == MB)))
                m_busy = 1'b0;
        end
    endtask

    // Compare process: mid-cycle, inputs and registered state are stable.
    always @(negedge clk) begin
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_rdy;
        logic          e_val;
        logic [DW-1:0] e_dat;
        if (!reset_n) model_reset();
        e_gnt = '0;
        e_rdy = '0;
        e_val = 1'b0;
        e_dat = m_hold;
        if (m_busy) begin
            e_gnt[m_g] = 1'b1;
            e_rdy[m_g] = i_ready_s;
            e_val      = i_req_valid[m_g];
            e_dat      = i_req_data[m_g*DW +: DW];
        end
        chk("o_grant", 32'(o_grant), 32'(e_gnt));
        chk("o_busy", 32'(o_busy), 32'(m_busy));
        chk("o_valid_s", 32'(o_valid_s), 32'(e_val));
        chk("o_data_s", 32'(o_data_s), 32'(e_dat));
        chk("o_req_ready", 32'(o_req_ready), 32'(e_rdy));
        if (!reset_n) begin
            cur_blen = 0;
            for (int k = 0; k < N; k++) waits[k] = 0;
        end else begin
            if (!prev_busy && o_busy) begin
                glog.push_back(int'(o_grant));
                for (int k = 0; k < N; k++) begin
                    if (o_grant[k]) waits[k] = 0;
                    else if (prev_valid[k] && i_req_valid[k]) waits[k]++;
                    if (waits[k] > N - 1) chk("starvation", 32'(waits[k]), 32'(N - 1));
                end
            end
            for (int k = 0; k < N; k++) if (!i_req_valid[k]) waits[k] = 0;
            if (o_valid_s && i_ready_s) begin
                cur_blen++;
                flog.push_back(int'(o_data_s));
            end
            if (prev_busy && !o_busy) begin
                blog.push_back(cur_blen);
                cur_blen = 0;
            end
            model_step();
        end
        prev_busy  = o_busy;
        prev_valid = i_req_valid;
    end

    task automatic drive_reqs();
        beat_t b;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                if (rq[k].size() > 0) void'(rq[k].pop_front());
                presenting[k] = 1'b0;
                acc[k]        = 1'b0;
            end
            if (!presenting[k] && rq[k].size() > 0) begin
                b = rq[k][0];
                if (b.gap > 0) begin
                    b.gap--;
                    rq[k][0] = b;
                end else begin
                    presenting[k] = 1'b1;
                end
            end
            i_req_valid[k] = presenting[k];
            if (presenting[k]) begin
                i_req_data[k*DW +: DW] = rq[k][0].data;
                i_req_last[k]          = rq[k][0].last;
            end else begin
                i_req_data[k*DW +: DW] = DW'($urandom);
                i_req_last[k]          = 1'($urandom);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_reqs();
    endtask

    task automatic add_beat(input int k, input int data, input logic last, input int gap);
        beat_t b;
        b.data = DW'(data);
        b.last = last;
        b.gap  = gap;
        rq[k].push_back(b);
    endtask

    task automatic add_burst(input int k, input int len, input int d0, input int gap0, input bit rnd);
        for (int i = 0; i < len; i++)
            add_beat(k, d0 + i, (i == len - 1),
                     (i == 0) ? gap0 : ((rnd && $urandom_range(0, 7) == 0) ? 1 : 0));
    endtask

    function automatic bit all_empty();
        bit e;
        e = (presenting == '0);
        for (int k = 0; k < N; k++) if (rq[k].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic clear_logs();
        glog.delete();
        blog.delete();
        flog.delete();
    endtask

    task automatic run_until_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            done = all_empty() && !o_busy;
        end
        tick();
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic wait_grant(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            got = o_busy;
        end
        chk(name, 32'(got), 32'd1);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_valid", 32'(o_valid_s), 32'd0);
        chk("rst_data", 32'(o_data_s), 32'd0);
        chk("rst_ready", 32'(o_req_ready), 32'd0);
        reset_n = 1'b1;

        // All four requesting single-beat bursts: strict rotation from requester 0.
        clear_logs();
        add_burst(0, 1, 8'h10, 0, 0);
        add_burst(0, 1, 8'h11, 0, 0);
        add_burst(1, 1, 8'h12, 0, 0);
        add_burst(2, 1, 8'h13, 0, 0);
        add_burst(3, 1, 8'h14, 0, 0);
        run_until_done("t1_done");
        exp_q = '{1, 2, 4, 8, 1};
        chk_log("t1_grants", glog, exp_q);
        exp_q = '{1, 1, 1, 1, 1};
        chk_log("t1_blen", blog, exp_q);

        // Almost-full blocks new grants; release picks requester 1 after last winner 0.
        clear_logs();
        i_almostfull = 1'b1;
        add_burst(1, 1, 8'h31, 0, 0);
        add_burst(3, 1, 8'h33, 0, 0);
        repeat (6) begin
            tick();
            chk("af_hold_grant", 32'(o_grant), 32'd0);
        end
        i_almostfull = 1'b0;
        tick();
        chk("af_release_grant", 32'(o_grant), 32'h2);
        run_until_done("t4_done");
        exp_q = '{2, 8};
        chk_log("t4_grants", glog, exp_q);

        // Almost-full raised mid-burst does not cut the burst short.
        clear_logs();
        add_burst(0, 3, 8'h40, 0, 0);
        wait_grant("t4b_grant");
        i_almostfull = 1'b1;
        run_until_done("t4b_done");
        i_almostfull = 1'b0;
        exp_q = '{3};
        chk_log("t4b_blen", blog, exp_q);
        exp_q = '{8'h40, 8'h41, 8'h42};
        chk_log("t4b_words", flog, exp_q);

        // Ten beats from requester 2 split by the burst limit into 4,4,2.
        clear_logs();
        add_burst(2, 10, 1, 0, 0);
        run_until_done("t2_done");
        exp_q = '{4, 4, 4};
        chk_log("t2_grants", glog, exp_q);
        exp_q = '{4, 4, 2};
        chk_log("t2_blen", blog, exp_q);
        exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        chk_log("t2_words", flog, exp_q);

        // FIFO back-pressure for three cycles in the middle of a burst.
        clear_logs();
        add_burst(1, 4, 8'h21, 0, 0);
        wait_grant("t3_grant");
        tick();
        i_ready_s = 1'b0;
        repeat (3) begin
            #1;
            chk("stall_valid", 32'(o_valid_s), 32'd1);
            chk("stall_ready", 32'(o_req_ready), 32'd0);
            chk("stall_data", 32'(o_data_s), 32'h22);
            tick();
        end
        i_ready_s = 1'b1;
        run_until_done("t3_done");
        exp_q = '{4};
        chk_log("t3_blen", blog, exp_q);
        exp_q = '{8'h21, 8'h22, 8'h23, 8'h24};
        chk_log("t3_words", flog, exp_q);

        // Requester 2 goes idle after two beats; requester 3 is served next.
        clear_logs();
        add_beat(2, 8'h51, 1'b0, 0);
        add_beat(2, 8'h52, 1'b0, 0);
        add_beat(2, 8'h53, 1'b0, 2);
        add_beat(2, 8'h54, 1'b1, 0);
        add_beat(3, 8'h60, 1'b1, 0);
        run_until_done("t5_done");
        exp_q = '{4, 8, 4};
        chk_log("t5_grants", glog, exp_q);
        exp_q = '{2, 1, 2};
        chk_log("t5_blen", blog, exp_q);
        exp_q = '{8'h51, 8'h52, 8'h60, 8'h53, 8'h54};
        chk_log("t5_words", flog, exp_q);

        // Asynchronous reset in the middle of a burst.
        clear_logs();
        for (int k = 0; k < N; k++) add_burst(k, 3, 8'h70 + 8 * k, 0, 0);
        wait_grant("t6_grant");
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_grant", 32'(o_grant), 32'd0);
        chk("async_rst_valid", 32'(o_valid_s), 32'd0);
        chk("async_rst_busy", 32'(o_busy), 32'd0);
        for (int k = 0; k < N; k++) rq[k].delete();
        presenting = '0;
        acc        = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) add_burst(k, 1, 8'h90 + k, 0, 0);
        wait_grant("t6_regrant");
        chk("post_rst_first_grant", 32'(o_grant), 32'h1);
        run_until_done("t6_done");

        // Randomized traffic, back-pressure and almost-full.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++)
                if (rq[k].size() < 6 && $urandom_range(0, 9) == 0)
                    add_burst(k, $urandom_range(1, 6), $urandom_range(0, 255), $urandom_range(0, 2), 1);
            i_ready_s = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) i_almostfull = ~i_almostfull;
            tick();
        end
        i_ready_s    = 1'b1;
        i_almostfull = 1'b0;
        run_until_done("random_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
